// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants for the decimal-to-BCD encoder.
//   N_DIGITS  width of the one-hot decimal input (10)
//   BCD_W     width of the BCD code (4)
//   SEG_*     7-segment patterns, active-high, bit order g f e d c b a
//   seg_of()  maps a BCD code (or an error flag) to its segment pattern;
//             used only when the BCD_SEG_OUT_EN build option is defined.
package bcd_pkg;

  localparam int N_DIGITS = 10;
  localparam int BCD_W    = 4;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  // An error always shows a dash, regardless of the code that came with it.
  function automatic logic [6:0] seg_of(input logic [BCD_W-1:0] code,
                                        input logic err);
    logic [6:0] s;
    s = SEG_DASH;
    if (!err) begin
      case (code)
        4'd0:    s = SEG_0;
        4'd1:    s = SEG_1;
        4'd2:    s = SEG_2;
        4'd3:    s = SEG_3;
        4'd4:    s = SEG_4;
        4'd5:    s = SEG_5;
        4'd6:    s = SEG_6;
        4'd7:    s = SEG_7;
        4'd8:    s = SEG_8;
        4'd9:    s = SEG_9;
        default: s = SEG_DASH;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/bcd_onehot_enc.sv
// bcd_onehot_enc: combinational one-hot to BCD priority encoder.
//   d_i      [N_DIGITS-1:0]  decimal digit lines, bit i = digit i
//   y_o      [BCD_W-1:0]     index of the highest set bit (0 when none set)
//   valid_o                  exactly one bit of d_i set
//   err_o                    d_i all-zero or more than one bit set
module bcd_onehot_enc
  import bcd_pkg::*;
(
  input  logic [N_DIGITS-1:0] d_i,
  output logic [BCD_W-1:0]    y_o,
  output logic                valid_o,
  output logic                err_o
);

  logic onehot;

  // Ascending scan: the last hit wins, giving priority to the larger digit.
  always_comb begin
    y_o = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (d_i[i]) y_o = BCD_W'(i);
    end
  end

  // Clearing the lowest set bit leaves zero only for a single-bit word.
  assign onehot  = (d_i != '0) && ((d_i & (d_i - N_DIGITS'(1))) == '0);
  assign valid_o = onehot;
  assign err_o   = ~onehot;

endmodule

// File: rtl/bcd.sv
// bcd: registered decimal-to-BCD encoder, front-end of the 7-segment path.
//   clk    system clock, rising edge
//   rst    asynchronous active-high reset
//   d      [9:0] one-hot decimal input
//   y      [3:0] registered BCD code (highest set digit wins)
//   valid  registered: sampled d was exactly one-hot
//   err    registered: sampled d was all-zero or multi-hot
//   seg    [6:0] registered segment pattern, g..a, dash on error
//          (present only when BCD_SEG_OUT_EN is defined)
// Latency from d to all outputs is one clock.
module bcd
  import bcd_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [N_DIGITS-1:0] d,
`ifdef BCD_SEG_OUT_EN
  output logic [6:0]          seg,
`endif
  output logic [BCD_W-1:0]    y,
  output logic                valid,
  output logic                err
);

  logic [BCD_W-1:0] y_d, y_q;
  logic             valid_d, valid_q;
  logic             err_d, err_q;

  bcd_onehot_enc u_enc (
    .d_i     (d),
    .y_o     (y_d),
    .valid_o (valid_d),
    .err_o   (err_d)
  );

  // Output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign y     = y_q;
  assign valid = valid_q;
  assign err   = err_q;

`ifdef BCD_SEG_OUT_EN
  logic [6:0] seg_d, seg_q;

  // Looked up from the unregistered code so seg lines up with y.
  assign seg_d = seg_of(y_d, err_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) seg_q <= 7'h00;
    else     seg_q <= seg_d;
  end

  assign seg = seg_q;
`endif

endmodule

// File: tb/tb_bcd.sv
module tb_bcd;

  typedef struct {
    logic [3:0] y;
    logic       valid;
    logic       err;
    logic [6:0] seg;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] d   = '0;
  logic [3:0] y;
  logic       valid;
  logic       err;
  logic [6:0] seg;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];

  bcd dut (
    .clk   (clk),
    .rst   (rst),
    .d     (d),
`ifdef BCD_SEG_OUT_EN
    .seg   (seg),
`endif
    .y     (y),
    .valid (valid),
    .err   (err)
  );

`ifndef BCD_SEG_OUT_EN
  assign seg = 7'h00;
`endif

  always #5 clk = ~clk;

  // Reference: digit = highest set bit, legal only when exactly one bit set.
  function automatic exp_t model(input logic [9:0] v);
    exp_t e;
    logic [6:0] pat [10];
    pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    e.y = 4'd0;
    for (int k = 9; k >= 0; k--) begin
      if (v[k]) begin
        e.y = 4'(k);
        break;
      end
    end
    e.valid = ($countones(v) == 1);
    e.err   = !e.valid;
    e.seg   = e.err ? 7'h40 : pat[e.y];
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, ".y"}, y, 0);
    chk({name, ".valid"}, valid, 0);
    chk({name, ".err"}, err, 0);
`ifdef BCD_SEG_OUT_EN
    chk({name, ".seg"}, seg, 0);
`endif
  endtask

  task automatic drive(input logic [9:0] v);
    @(negedge clk);
    d = v;
    exp_q.push_back(model(v));
  endtask

  // Monitor: outputs present a new result after every edge out of reset.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("y", y, e.y);
      chk("valid", valid, e.valid);
      chk("err", err, e.err);
      chk("valid_err_excl", valid & err, 0);
`ifdef BCD_SEG_OUT_EN
      chk("seg", seg, e.seg);
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] v;
    #1;
    chk_reset_vals("reset_init");
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset_hold");
    @(negedge clk);
    rst = 1'b0;

    // walking one
    for (int i = 0; i < 10; i++) drive(10'd1 << i);
    // all-zero, multi-hot, back-to-back
    drive(10'b0000000000);
    drive(10'b1000000001);
    drive(10'b0000100100);
    drive(10'b0000000100);
    drive(10'b0100000000);
    drive(10'b0000010000);
    drive(10'b1111111111);

    // mid-stream asynchronous reset discards the in-flight sample
    drive(10'b1000000000);
    drive(10'b0000001000);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk_reset_vals("reset_async");
    @(posedge clk);
    #1;
    chk_reset_vals("reset_mid_hold");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_vals("reset_release");

    // randomized mix of one-hot, zero and arbitrary patterns
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       v = 10'd1 << $urandom_range(0, 9);
        1:       v = 10'd0;
        default: v = 10'($urandom);
      endcase
      drive(v);
    end

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results pending, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
